// File: rtl/clk_divider_multi.sv
// clk_divider_multi
//   Multi-channel clock divider running on the 100 MHz fabric clock. Each
//   channel outputs a 50 %-duty square wave whose level lasts a programmable
//   number of cycles (the "half" period), plus a one-cycle tick on every rising
//   toggle. New half values arrive through a valid/ready load port. They are
//   held as pending and only switched in at a toggle boundary, so the output
//   never shows a runt pulse.
//
// Ports
//   clk100Mhz   fast clock; every register updates on its rising edge
//   resetn      synchronous reset, active low; overrides all other inputs
//   enable      per-channel run enable; low freezes that channel
//   sync        one-cycle pulse that realigns every channel to the reset phase
//   load_valid  load request
//   load_ch     channel the load targets
//   load_half   new half period in cycles (0 is treated as 1)
//   load_ready  load can be taken this cycle (combinational)
//   slowClk     divided clock per channel (registered)
//   tick        one-cycle pulse in the cycle slowClk goes 0->1 (registered)

// One divider lane: counter, active/pending half period, output flop.
module clk_divider_ch #(
    parameter int CNT_W        = 28,
    parameter int DEFAULT_HALF = 30000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] half,
    output logic             pending,
    output logic             slow_clk,
    output logic             tick
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] pend;
    logic             terminal;

    // cnt runs 1..act, so the increment below can never wrap.
    assign terminal = (cnt == act);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt      <= ONE;
            act      <= DEF;
            pend     <= DEF;
            pending  <= 1'b0;
            slow_clk <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (sync) begin
                cnt      <= ONE;
                slow_clk <= 1'b0;
                if (pending) begin
                    act     <= pend;
                    pending <= 1'b0;
                end
            end else if (en) begin
                if (terminal) begin
                    // The toggle ends the half period that ran on the old act.
                    // A pending value governs the half period starting now.
                    cnt      <= ONE;
                    slow_clk <= ~slow_clk;
                    tick     <= ~slow_clk;
                    if (pending) begin
                        act     <= pend;
                        pending <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + ONE;
                end
            end
            // A load is only accepted while nothing is pending. It therefore
            // never collides with an apply in the same cycle. A load that
            // coincides with a terminal waits for the next terminal.
            if (load) begin
                pend    <= half;
                pending <= 1'b1;
            end
        end
    end
endmodule

module clk_divider_multi #(
    parameter  int NUM_CH       = 4,
    parameter  int CNT_W        = 28,
    parameter  int DEFAULT_HALF = 30000,
    localparam int CH_W         = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk100Mhz,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] enable,
    input  logic              sync,
    input  logic              load_valid,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [CNT_W-1:0]  load_half,
    output logic              load_ready,
    output logic [NUM_CH-1:0] slowClk,
    output logic [NUM_CH-1:0] tick
);
    // Extra bit so the range check still works when NUM_CH is a power of two.
    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] pv;
    logic              pv_sel;
    logic              ch_ok;
    logic              accept;
    logic [CNT_W-1:0]  half_c;

    // Mux pv by load_ch without indexing past the array for unused codes.
    always_comb begin
        pv_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load_ch == CH_W'(i)) pv_sel = pv[i];
        end
    end

    assign ch_ok      = ({1'b0, load_ch} < NUM_CH_V);
    assign load_ready = ch_ok && !pv_sel;
    assign accept     = load_valid && load_ready;
    assign half_c     = (load_half == '0) ? CNT_W'(1) : load_half;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_divider_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_HALF(DEFAULT_HALF)
        ) u_ch (
            .clk     (clk100Mhz),
            .resetn  (resetn),
            .en      (enable[g]),
            .sync    (sync),
            .load    (accept && (load_ch == CH_W'(g))),
            .half    (half_c),
            .pending (pv[g]),
            .slow_clk(slowClk[g]),
            .tick    (tick[g])
        );
    end
endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi. The reference model is a period-level
// description: each channel's level is ph ^ ((k / H) % 2), where k counts
// enabled edges since the channel's last phase origin. The origin is set by a
// reset, a sync or a half-period switch. Expected values are queued when the
// stimulus for an edge is driven, then popped and compared after that edge.
module tb_clk_divider_multi;
    localparam int NUM_CH = 5;
    localparam int CNT_W  = 8;
    localparam int DEF    = 4;
    localparam int CH_W   = 3;

    logic              clk100Mhz  = 1'b0;
    logic              resetn     = 1'b0;
    logic [NUM_CH-1:0] enable     = '1;
    logic              sync       = 1'b0;
    logic              load_valid = 1'b0;
    logic [CH_W-1:0]   load_ch    = '0;
    logic [CNT_W-1:0]  load_half  = '0;
    logic              load_ready;
    logic [NUM_CH-1:0] slowClk;
    logic [NUM_CH-1:0] tick;

    clk_divider_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_HALF(DEF)
    ) dut (
        .clk100Mhz (clk100Mhz),
        .resetn    (resetn),
        .enable    (enable),
        .sync      (sync),
        .load_valid(load_valid),
        .load_ch   (load_ch),
        .load_half (load_half),
        .load_ready(load_ready),
        .slowClk   (slowClk),
        .tick      (tick)
    );

    always #5 clk100Mhz = ~clk100Mhz;

    typedef struct {
        string tag;
        int    ch;
        int    kind;   // 0 slowClk, 1 tick, 2 load_ready
        logic  expv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    // Model state.
    int   n = 0;
    int   base   [NUM_CH];
    int   hh     [NUM_CH];
    int   pend_m [NUM_CH];
    logic ph     [NUM_CH];
    logic pv_m   [NUM_CH];
    logic last   [NUM_CH];

    function automatic int pos(input int c);
        return (n - base[c]) % hh[c];
    endfunction

    task automatic check(input string tag, input int ch, input int kind,
                         input logic obs, input logic expv);
        string kn;
        kn = (kind == 0) ? "slowClk" : (kind == 1) ? "tick" : "load_ready";
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s ch%0d %s: got %b expected %b", tag, ch, kn, obs, expv);
        end
    endtask

    // One clock edge with the currently driven inputs.
    task automatic cyc(input string tag);
        logic acc;
        logic es;
        logic et;
        logic rdy;
        int   k;
        int   lc;
        exp_t e;
        logic obs;
        lc  = int'(load_ch);
        acc = 1'b0;
        if (resetn && load_valid && lc < NUM_CH) acc = !pv_m[lc];
        n++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!resetn) begin
                base[c] = n; ph[c] = 1'b0; hh[c] = DEF; pv_m[c] = 1'b0;
                es = 1'b0; et = 1'b0;
            end else if (sync) begin
                base[c] = n; ph[c] = 1'b0;
                if (pv_m[c]) begin hh[c] = pend_m[c]; pv_m[c] = 1'b0; end
                es = 1'b0; et = 1'b0;
            end else if (!enable[c]) begin
                base[c] = base[c] + 1;
                es = last[c]; et = 1'b0;
            end else begin
                k  = n - base[c];
                es = ph[c] ^ (((k / hh[c]) % 2) == 1);
                et = ((k % hh[c]) == 0) && es;
                if ((k % hh[c]) == 0 && pv_m[c]) begin
                    base[c] = n; ph[c] = es; hh[c] = pend_m[c]; pv_m[c] = 1'b0;
                end
            end
            last[c] = es;
            sb.push_back('{tag, c, 0, es});
            sb.push_back('{tag, c, 1, et});
        end
        if (acc) begin
            pend_m[lc] = (load_half == '0) ? 1 : int'(load_half);
            pv_m[lc]   = 1'b1;
        end
        rdy = 1'b0;
        if (lc < NUM_CH) rdy = !pv_m[lc];
        sb.push_back('{tag, lc, 2, rdy});

        @(posedge clk100Mhz);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = slowClk[e.ch];
                1:       obs = tick[e.ch];
                default: obs = load_ready;
            endcase
            check(e.tag, e.ch, e.kind, obs, e.expv);
        end
    endtask

    task automatic run(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) cyc(tag);
    endtask

    // Advance until channel c sits at the wanted position in its half period.
    task automatic run_until(input int c, input int want, input string tag);
        for (int i = 0; i < 32; i++) begin
            if (pos(c) == want) break;
            cyc(tag);
        end
        n_checks++;
        assert (pos(c) == want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s bound: position %0d expected %0d", tag, pos(c), want);
        end
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            base[c] = 0; hh[c] = DEF; pend_m[c] = DEF;
            ph[c] = 1'b0; pv_m[c] = 1'b0; last[c] = 1'b0;
        end

        // Reset with a load request held high: nothing may be accepted.
        resetn = 1'b0; enable = '1; load_valid = 1'b1; load_ch = 0; load_half = 9;
        run(3, "reset");
        load_valid = 1'b0; resetn = 1'b1;
        run(12, "post_reset");

        // Reload ch1 in the middle of its high phase.
        load_ch = 1; load_half = 2; load_valid = 1'b1;
        cyc("reload_acc");
        load_valid = 1'b0;
        cyc("reload_pend");
        load_ch = 0;
        cyc("reload_ch0_ready");
        load_ch = 1;
        run(8, "reload_new");

        // A zero load on ch2 clamps to 1.
        load_ch = 2; load_half = 0; load_valid = 1'b1;
        cyc("clamp_acc");
        load_valid = 1'b0;
        run(10, "clamp");

        // Freeze ch0 for 5 cycles at cnt=2.
        run_until(0, 1, "freeze_align");
        enable[0] = 1'b0;
        run(5, "freeze");
        enable[0] = 1'b1;
        run(10, "resume");

        // Out-of-range channel is never ready and is ignored.
        load_ch = 6; load_half = 7; load_valid = 1'b1;
        cyc("oor");
        load_valid = 1'b0;

        // Set ch0 to H=3 and ch3 to H=5, then realign with sync.
        load_ch = 0; load_half = 3; load_valid = 1'b1;
        cyc("h3_acc");
        load_ch = 3; load_half = 5;
        cyc("h5_acc");
        load_valid = 1'b0;
        run(12, "h35");
        load_ch = 1; load_half = 6; load_valid = 1'b1;
        cyc("sync_pend");
        load_valid = 1'b0; sync = 1'b1; enable[4] = 1'b0;
        cyc("sync");
        sync = 1'b0;
        run(2, "sync_dis");
        enable[4] = 1'b1;
        run(14, "post_sync");

        // Reset while a load on ch3 is still pending.
        load_ch = 3;
        run_until(3, 0, "rml_align");
        load_half = 7; load_valid = 1'b1;
        cyc("rml_acc");
        load_valid = 1'b0;
        run_until(3, 3, "rml_wait");
        resetn = 1'b0;
        cyc("rml_rst");
        resetn = 1'b1;
        run(12, "rml_post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/clk_divider_multi.md
# clk_divider_multi

Parametrised multi-channel clock divider for the 100 MHz fabric clock. Each of NUM_CH channels produces a 50 %-duty square wave slowClk[i] with period 2·half_i cycles, plus a one-cycle rising-edge tick. Half-period values are programmed at run time through a valid/ready load port and take effect glitch-free at the next toggle boundary. The block feeds display multiplexing, debouncers and other slow timing consumers that today use fixed single-channel dividers.

## Interface
- NUM_CH, 4, number of independent divider channels (≥1)
- CNT_W, 28, counter and half-period width in bits
- DEFAULT_HALF, 30000, half-period loaded into every channel at reset (1 ≤ DEFAULT_HALF < 2^CNT_W)
- CH_W (localparam), max(1, $clog2(NUM_CH)), width of load_ch

- clk100Mhz  input  1  fast clock; all logic on its rising edge
- resetn  input  1  synchronous reset, active-low
- enable  input  NUM_CH  per-channel run enable; low freezes that channel
- sync  input  1  one-cycle realign pulse for all channels
- load_valid  input  1  half-period load request
- load_ch  input  CH_W  target channel of load
- load_half  input  CNT_W  new half-period in cycles
- load_ready  output  1  load can be accepted this cycle
- slowClk  output  NUM_CH  divided clock per channel
- tick  output  NUM_CH  one-cycle pulse in the cycle slowClk[i] goes 0→1

## Operation
- Per channel i: counter cnt[i] (CNT_W), active half act[i], pending half pend[i], pending flag pv[i], output slowClk[i], tick[i].
- Reset (resetn=0 at a clock edge): cnt=1, act=DEFAULT_HALF, pv=0, slowClk=0, tick=0, all channels. Reset overrides every other input.
- Count (enable[i]=1, sync=0): if cnt[i]==act[i] → cnt[i]<=1, slowClk[i]<=~slowClk[i] (terminal cycle); else cnt[i]<=cnt[i]+1.
- tick[i]<=1 only in a terminal cycle where slowClk[i] is 0 (rising toggle); otherwise 0.
- enable[i]=0: cnt[i], slowClk[i] hold; tick[i]=0; pending load stays pending.
- sync=1 (priority over count, all channels regardless of enable): cnt=1, slowClk=0, tick=0; if pv[i], act[i]<=pend[i] and pv[i]<=0.
- Load handshake: load_ready = (load_ch < NUM_CH) && !pv[load_ch] (combinational). Accept when load_valid && load_ready: pend[load_ch]<=(load_half==0 ? 1 : load_half), pv<=1.
- Apply: in the terminal cycle of channel i with pv[i]=1, act[i]<=pend[i], pv[i]<=0. That terminal cycle's toggle uses the old act; the new value governs the next half-period. cnt never exceeds act.
- Load accepted in the same cycle as a terminal of that channel: does not apply that cycle; applies at the following terminal.
- load_ch ≥ NUM_CH: load_ready=0, request ignored.
- Arithmetic: unsigned, CNT_W bits; increment cannot overflow since cnt ≤ act < 2^CNT_W.

## Timing
- Half-period H: slowClk[i] holds each level exactly H cycles; period 2H; H=1 gives toggle every cycle.
- After resetn rises (first edge with resetn=1 is edge 1, cnt=1 in cycle after reset), slowClk[i] first goes high at edge H and tick[i] is high for the cycle following that edge.
- After sync: identical timing to post-reset, all enabled channels phase-aligned.
- Load latency: new half effective from first half-period starting after the next terminal of that channel; at most 2·H_old cycles plus any disabled time.
- Outputs are registered (except load_ready); no combinational path from enable or sync to slowClk/tick.
- Reset mid-operation: next cycle all state equals reset values, pending loads discarded.

## Test plan
- Reset values: hold resetn=0 3 cycles with enable=all-1, load_valid=1 -> slowClk=0, tick=0, no load applied; release, DEFAULT_HALF=4 -> slowClk[0] rises at edge 4, tick[0] one cycle, falls at edge 8.
- Runtime reload: ch1 at H=4, mid-high-phase load_half=2 -> current high phase still 4 cycles, low phase then 2 cycles; load_ready low for ch1 until applied, high for ch0.
- Clamp and minimum: load_half=0 on ch2 -> act=1, slowClk[2] toggles every cycle, tick every 2nd cycle.
- Enable freeze: drop enable[0] for 5 cycles at cnt=2 -> slowClk[0] and cnt hold, no tick; resume, remaining half-period lengthened by exactly 5 cycles.
- Sync realign: channels with H=3 and H=5 out of phase, pulse sync -> all slowClk=0 next cycle, pending load applied, rising edges at 3 and 5 cycles later.
- Reset mid-load: accept load on ch3, assert resetn=0 one cycle before its terminal -> act[3]=DEFAULT_HALF, pv[3]=0, load_ready=1 afterwards.
